// File: rtl/dm_cache_fsm_pkg.sv
// cache_definition: shared request/response types and tag geometry for the direct-mapped cache.
package cache_definition;
  localparam int ADDR_W = 20;
  localparam int TAG_MSB = ADDR_W - 1;
  localparam int TAG_LSB = 10;
  localparam int TAG_W = TAG_MSB - TAG_LSB + 1;
  typedef enum logic [1:0] {IDLE, COMPARE_TAG, ALLOCATE, WRITE_BACK} cache_state_type;
  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } cache_tag_type;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              rw;
    logic              valid;
  } cpu_req_type;
  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;
  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } mem_to_cache_type;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              rw;
    logic              valid;
  } cache_to_mem_type;
endpackage

// File: rtl/dm_cache_fsm_line_store.sv
// cache_line_store: per-line tag/data arrays, combinational read, sync write, async valid/dirty clear.
module cache_line_store
  import cache_definition::*;
#(
  parameter int INDEX_BITS = TAG_LSB
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [INDEX_BITS-1:0] index_i,
  input  logic                  tag_we_i,
  input  cache_tag_type         tag_i,
  input  logic                  data_we_i,
  input  logic [31:0]           data_i,
  output cache_tag_type         tag_o,
  output logic [31:0]           data_o
);
  localparam int LINES = 1 << INDEX_BITS;
  logic [LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [31:0]      data_q [LINES];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (tag_we_i) begin
      valid_q[index_i] <= tag_i.valid;
      dirty_q[index_i] <= tag_i.dirty;
    end
  // Tags and data survive reset; only the status bits are cleared.
  always_ff @(posedge clk_i) begin
    if (tag_we_i) tag_q[index_i] <= tag_i.tag;
    if (data_we_i) data_q[index_i] <= data_i;
  end
  assign tag_o = '{valid: valid_q[index_i], dirty: dirty_q[index_i], tag: tag_q[index_i]};
  assign data_o = data_q[index_i];
endmodule

// File: rtl/dm_cache_fsm.sv
// dm_cache_fsm: direct-mapped write-back write-allocate cache controller, one word per line.
module dm_cache_fsm
  import cache_definition::*;
#(
  parameter int INDEX_BITS = TAG_LSB
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  cpu_req_type      cpu_req_i,
  input  mem_to_cache_type mem_to_cache_i,
  output cpu_result_type   cpu_res_o,
  output cache_to_mem_type cache_to_mem_o
);
  cache_state_type       state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  rw_q, rw_d;
  cache_tag_type         tag_rd, tag_wr;
  logic [31:0]           data_rd, data_wr;
  logic                  tag_we, data_we, hit, mem_done;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_W-1:0]      req_tag;
  assign index = addr_q[INDEX_BITS-1:0];
  assign req_tag = TAG_W'(addr_q >> INDEX_BITS);
  assign hit = tag_rd.valid && tag_rd.tag == req_tag;
  assign mem_done = mem_to_cache_i.ready;
  cache_line_store #(.INDEX_BITS(INDEX_BITS)) u_store (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .index_i  (index),
    .tag_we_i (tag_we),
    .tag_i    (tag_wr),
    .data_we_i(data_we),
    .data_i   (data_wr),
    .tag_o    (tag_rd),
    .data_o   (data_rd)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
    end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    case (state_q)
      IDLE: if (cpu_req_i.valid) begin
        addr_d  = cpu_req_i.addr;
        wdata_d = cpu_req_i.data;
        rw_d    = cpu_req_i.rw;
        state_d = COMPARE_TAG;
      end
      COMPARE_TAG: state_d = hit ? IDLE : (tag_rd.valid && tag_rd.dirty) ? WRITE_BACK : ALLOCATE;
      WRITE_BACK:  state_d = mem_done ? ALLOCATE : WRITE_BACK;
      ALLOCATE:    state_d = mem_done ? COMPARE_TAG : ALLOCATE;
      default:     state_d = IDLE;
    endcase
  end
  // A refill lands clean; a write hit marks the line dirty. Both reuse the same write port.
  always_comb begin
    tag_we  = (state_q == ALLOCATE && mem_done) || (state_q == COMPARE_TAG && hit && rw_q);
    data_we = tag_we;
    tag_wr  = '{valid: 1'b1, dirty: state_q == COMPARE_TAG, tag: req_tag};
    data_wr = state_q == ALLOCATE ? mem_to_cache_i.data : wdata_q;
    cpu_res_o = '{data: data_rd, ready: state_q == COMPARE_TAG && hit};
    cache_to_mem_o.valid = (state_q == WRITE_BACK || state_q == ALLOCATE) && !mem_done;
    cache_to_mem_o.rw    = state_q == WRITE_BACK;
    cache_to_mem_o.addr  = state_q == WRITE_BACK ? ADDR_W'({tag_rd.tag, index}) : addr_q;
    cache_to_mem_o.data  = data_rd;
  end
endmodule

// File: tb/tb_dm_cache_fsm.sv
// tb_dm_cache_fsm: directed bench with a wait-state programmable memory responder.
module tb_dm_cache_fsm;
  import cache_definition::*;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  cpu_req_type      cpu_req = '0;
  cpu_result_type   cpu_res;
  mem_to_cache_type m2c;
  cache_to_mem_type c2m;
  int n_cmp = 0, n_bad = 0;
  int mem_wait = 2;
  logic [31:0] ram [0:2047];
  logic        mrdy = 1'b0;
  logic [31:0] mdata = '0;
  int run = 0, nrd = 0, nwr = 0, unstable = 0, dup = 0, last_vcyc = 0;
  logic [19:0] last_wa = '0, last_ra = '0;
  logic [31:0] last_wd = '0;
  logic [52:0] first = '0;

  dm_cache_fsm dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cpu_req_i     (cpu_req),
    .mem_to_cache_i(m2c),
    .cpu_res_o     (cpu_res),
    .cache_to_mem_o(c2m)
  );

  always #5 clk = ~clk;
  assign m2c = '{data: mdata, ready: mrdy};

  always @(posedge clk)
    if (!rst_n) begin
      mrdy <= 1'b0;
      run  <= 0;
    end else begin
      mrdy <= 1'b0;
      if (c2m.valid) begin
        if (mrdy) dup <= dup + 1;
        if (run == 0) first <= {c2m.addr, c2m.data, c2m.rw};
        else if (first != {c2m.addr, c2m.data, c2m.rw}) unstable <= unstable + 1;
        if (run == mem_wait - 1) begin
          mrdy <= 1'b1;
          run <= 0;
          last_vcyc <= run + 1;
          if (c2m.rw) begin
            ram[c2m.addr[10:0]] <= c2m.data;
            nwr <= nwr + 1;
            last_wa <= c2m.addr;
            last_wd <= c2m.data;
          end else begin
            mdata <= ram[c2m.addr[10:0]];
            nrd <= nrd + 1;
            last_ra <= c2m.addr;
          end
        end else run <= run + 1;
      end
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cpu_op(input string t, input logic [19:0] a, input logic [31:0] d, input logic w,
                        input int lat, input logic [31:0] exp_d, input int d_rd, input int d_wr);
    int k, rd0, wr0;
    rd0 = nrd;
    wr0 = nwr;
    @(negedge clk);
    cpu_req = '{addr: a, data: d, rw: w, valid: 1'b1};
    @(posedge clk);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cpu_res.ready && k < 100);
    cpu_req.valid = 1'b0;
    check({t, " latency"}, 32'(k), 32'(lat));
    if (!w) check({t, " data"}, cpu_res.data, exp_d);
    @(negedge clk);
    check({t, " mem reads"}, 32'(nrd - rd0), 32'(d_rd));
    check({t, " mem writes"}, 32'(nwr - wr0), 32'(d_wr));
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 32'h0;
    ram[11'h005] = 32'hDEADBEEF;
    ram[11'h405] = 32'h0BADF00D;
    ram[11'h010] = 32'h11111111;
    ram[11'h410] = 32'h44444444;
    ram[11'h020] = 32'h22222222;
    repeat (3) @(negedge clk);
    check("reset cpu ready", 32'(cpu_res.ready), 32'h0);
    check("reset mem valid", 32'(c2m.valid), 32'h0);
    check("reset mem rw", 32'(c2m.rw), 32'h0);
    rst_n = 1'b1;
    cpu_op("cold read miss", 20'h00005, 32'h0, 1'b0, 5, 32'hDEADBEEF, 1, 0);
    check("cold read addr", 32'(last_ra), 32'h00005);
    cpu_op("read hit", 20'h00005, 32'h0, 1'b0, 1, 32'hDEADBEEF, 0, 0);
    cpu_op("write hit", 20'h00005, 32'h12345678, 1'b1, 1, 32'h0, 0, 0);
    cpu_op("read after write", 20'h00005, 32'h0, 1'b0, 1, 32'h12345678, 0, 0);
    cpu_op("dirty evict", 20'h00405, 32'h0, 1'b0, 8, 32'h0BADF00D, 1, 1);
    check("evict wr addr", 32'(last_wa), 32'h00005);
    check("evict wr data", last_wd, 32'h12345678);
    check("evict ram[5]", ram[11'h005], 32'h12345678);
    check("evict rd addr", 32'(last_ra), 32'h00405);
    cpu_op("write miss clean", 20'h00010, 32'hCAFEF00D, 1'b1, 5, 32'h0, 1, 0);
    cpu_op("read write-alloc", 20'h00010, 32'h0, 1'b0, 1, 32'hCAFEF00D, 0, 0);
    mem_wait = 6;
    cpu_op("wait-state evict", 20'h00410, 32'h0, 1'b0, 16, 32'h44444444, 1, 1);
    check("wait wr addr", 32'(last_wa), 32'h00010);
    check("wait wr data", last_wd, 32'hCAFEF00D);
    check("wait valid cycles", 32'(last_vcyc), 32'd6);
    check("wait unstable", 32'(unstable), 32'd0);
    check("valid with ready", 32'(dup), 32'd0);
    @(negedge clk);
    cpu_req = '{addr: 20'h00020, data: 32'h0, rw: 1'b0, valid: 1'b1};
    @(posedge clk);
    repeat (3) @(negedge clk);
    check("alloc valid", 32'(c2m.valid), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("rst mem valid", 32'(c2m.valid), 32'h0);
    check("rst mem rw", 32'(c2m.rw), 32'h0);
    check("rst cpu ready", 32'(cpu_res.ready), 32'h0);
    cpu_req.valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_wait = 2;
    cpu_op("miss after reset", 20'h00410, 32'h0, 1'b0, 5, 32'h44444444, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
